softmax_seq: RTL and testbench
==============================

Name: softmax_seq

Overview:
- Parametrised, handshaked successor to the single-shot softmax.
- Accepts one vector of LANES signed integers from the output buffer and emits LANES softmax probabilities in unsigned-magnitude fixed point (INT_W.FRAC_W).
- Data path: max subtraction, LUT exponent, accumulation and a shared sequential divider. A bypass mode converts integers to fixed point with no softmax.
- Sits between the systolic-array output buffer and the attention write-back path.

Parameters:
- LANES, 4, number of vector elements (ARRAYWIDTH).
- IN_W, 32, signed input element width (OUTPUT_BUF_DATASIZE).
- INT_W, 22, output integer bits (FIXPOINT_INT).
- FRAC_W, 10, output fraction bits (FIXPOINT_FRAC).
- LUT_DEPTH, 8, number of exp LUT entries; distance >= LUT_DEPTH gives exp = 0.

Ports:
- clk, input, 1, clock; all flops rising edge.
- rst, input, 1, asynchronous, active-low reset.
- softmax_en, input, 1, mode sampled on accept: 1 = softmax, 0 = bypass.
- in_valid, input, 1, input vector valid.
- in_ready, output, 1, block can accept a vector.
- Xi, input, LANES*IN_W, signed elements; lane 0 in the LSBs.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts the result.
- out, output, LANES*(INT_W+FRAC_W), fixed-point results; lane 0 in the LSBs.

Behaviour:
- Reset (rst=0, async): state IDLE; out_valid=0; out=0; in_ready=1 once IDLE is reached. Internal registers are cleared. Asserting reset mid-operation aborts the operation; no partial result is ever presented.
- Accept: fires when in_valid && in_ready. Xi, softmax_en (and temp_shift, if compiled in) are registered. in_ready=1 only in IDLE. in_valid in any other state is ignored.
- States:
  - IDLE: on accept, go to BYP if softmax_en=0, else MAX.
  - BYP (1 cycle): out_i = Xi_i << FRAC_W as signed two's complement. Saturate to 0x7FFF_FFFF or 0x8000_0000 if |Xi_i| exceeds the INT_W signed range. Go to DONE.
  - MAX (LANES cycles): scan one lane per cycle and track the signed maximum; ties are harmless.
  - EXP (LANES cycles): d_i = max − Xi_i computed in IN_W+1 bits, always ≥ 0. e_i = LUT[d_i] if d_i < LUT_DEPTH, else 0. Accumulate sum += e_i in FRAC_W + clog2(LANES) + 1 bits.
  - DIV (LANES × (FRAC_W+2) cycles): per lane, 1 load cycle plus FRAC_W+1 restoring-division iterations. out_i = floor(e_i × 2^FRAC_W / sum), with the upper bits zero-filled. sum ≥ 2^FRAC_W because the max lane contributes LUT[0], so no divide-by-zero path is needed.
  - DONE: out_valid=1; out is held stable until out_ready=1. On that edge, out_valid drops and the FSM returns to IDLE. out_ready while out_valid=0 has no effect.
- Latency from the accept edge to out_valid rising:
  - Softmax: 2×LANES + LANES×(FRAC_W+2) + 1 cycles (57 at defaults).
  - Bypass: 2 cycles.
- LUT, Q.FRAC_W = round(2^FRAC_W × e^−d): 1024, 377, 139, 51, 19, 7, 3, 1.
- Throughput: one vector in flight; no overlap between accept and output.

Optional Feature:
- Macro: SOFTMAX_TEMP_EN.
- Defined: adds input port temp_shift [1:0], sampled on accept. The LUT index becomes d_i >> temp_shift, a logical shift of the non-negative distance. Timing is unchanged.
- Undefined: the port is absent and the shift is 0; behaviour is identical to temp_shift=0.

Decomposition:
- config.v holds ARRAYWIDTH, OUTPUT_BUF_DATASIZE, FIXPOINT_INT/FRAC, the SOFTMAX_LUT_DEPTH default, the exp LUT constants and the FSM state encodings.
- One sub-module: softmax_div_seq, the restoring divider. Interface: start, dividend, divisor, busy/done, quotient; FRAC_W+2 cycles per division.

Test Plan:
- Basic: softmax_en=1, Xi=128'h00000001_00000002_00000003_00000004 → out lanes3..0 = 32, 89, 242, 659; out_valid 57 cycles after accept.
- Equal inputs: all lanes = 7 → every lane 256.
- Signed and large spread: lanes3..0 = −100 (32'hFFFFFF9C), 0, 50, 50 → 0, 0, 512, 512.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → out stable, in_ready=0, a concurrent in_valid is ignored. out_ready=1 → in_ready=1 next cycle.
- Bypass: softmax_en=0, lanes = 3, −2, 0x00400000, 0 → 3072, 32'hFFFFF800, 32'h7FFFFFFF, 0; out_valid 2 cycles after accept.
- Reset and temperature:
  - rst=0 at cycle 20 of an operation → out_valid=0 immediately, in_ready=1 after release.
  - With SOFTMAX_TEMP_EN, temp_shift=1 on the basic vector → lanes3..0 = 137, 137, 374, 374.

Source files
------------

// File: rtl/softmax_seq_pkg.sv
// Shared configuration for the sequential softmax block: default vector
// geometry, fixed-point format, exponent lookup table and FSM encodings.
package softmax_seq_pkg;

    // Default vector geometry and fixed-point format
    localparam int ARRAYWIDTH          = 4;
    localparam int OUTPUT_BUF_DATASIZE = 32;
    localparam int FIXPOINT_INT        = 22;
    localparam int FIXPOINT_FRAC       = 10;
    localparam int SOFTMAX_LUT_DEPTH   = 8;

    // Width of one exp LUT entry (Q.10, largest entry is 1.0 = 1024)
    localparam int EXP_LUT_W = 11;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_BYP  = 3'd1;
    localparam logic [2:0] ST_MAX  = 3'd2;
    localparam logic [2:0] ST_EXP  = 3'd3;
    localparam logic [2:0] ST_DIV  = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    // round(1024 * e^-d) for d = 0..7; the table holds eight entries, so
    // any index beyond it reads as zero.
    function automatic logic [EXP_LUT_W-1:0] exp_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    exp_lut = 11'd1024;
            4'd1:    exp_lut = 11'd377;
            4'd2:    exp_lut = 11'd139;
            4'd3:    exp_lut = 11'd51;
            4'd4:    exp_lut = 11'd19;
            4'd5:    exp_lut = 11'd7;
            4'd6:    exp_lut = 11'd3;
            4'd7:    exp_lut = 11'd1;
            default: exp_lut = 11'd0;
        endcase
    endfunction

endpackage

// File: rtl/softmax_div_seq.sv
// Restoring unsigned divider. One cycle loads the operands, then Q_W
// iterations each resolve one quotient bit from the MSB down, so a full
// division takes Q_W+1 cycles. done pulses for one cycle with the quotient,
// which then holds until the next start. The caller guarantees that the
// quotient fits in Q_W bits.
module softmax_div_seq #(
    parameter int DVD_W = 21,
    parameter int DVS_W = 13,
    parameter int Q_W   = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [Q_W-1:0]   quotient
);

    localparam int DSH_W = DVS_W + Q_W - 1;
    localparam int CMP_W = (DSH_W > DVD_W) ? DSH_W : DVD_W;
    localparam int CNT_W = $clog2(Q_W) + 1;

    logic [CMP_W-1:0] rem_r;
    logic [CMP_W-1:0] dsh_r;
    logic [Q_W-1:0]   q_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;
    logic             fits_s;
    logic [CMP_W-1:0] diff_s;
    logic             last_s;

    // Trial subtraction of the shifted divisor; keep the remainder if it would go negative
    always_comb begin
        if (rem_r >= dsh_r) begin
            fits_s = 1'b1;
            diff_s = rem_r - dsh_r;
        end else begin
            fits_s = 1'b0;
            diff_s = rem_r;
        end
    end

    assign last_s = (cnt_r == CNT_W'(Q_W - 1));

    // Load on start, then iterate one quotient bit per cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_r  <= '0;
            dsh_r  <= '0;
            q_r    <= '0;
            cnt_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (start && !busy_r) begin
            rem_r  <= CMP_W'(dividend);
            dsh_r  <= CMP_W'(divisor) << (Q_W - 1);
            q_r    <= '0;
            cnt_r  <= '0;
            busy_r <= 1'b1;
            done_r <= 1'b0;
        end else if (busy_r) begin
            rem_r  <= diff_s;
            q_r    <= {q_r[Q_W-2:0], fits_s};
            dsh_r  <= dsh_r >> 1;
            cnt_r  <= cnt_r + CNT_W'(1);
            busy_r <= !last_s;
            done_r <= last_s;
        end else begin
            done_r <= 1'b0;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign quotient = q_r;

endmodule

// File: rtl/softmax_seq.sv
// Sequential, handshaked softmax over one vector of LANES signed integers.
// Softmax path: max scan, LUT exponent with accumulation, then one shared
// restoring divider per lane. Bypass path converts each integer to
// INT_W.FRAC_W fixed point with saturation.
// Optional build macro SOFTMAX_TEMP_EN adds a temp_shift[1:0] input that
// right-shifts the LUT distance (a softer distribution); without it the
// shift is zero.
module softmax_seq
    import softmax_seq_pkg::*;
#(
    parameter int LANES     = ARRAYWIDTH,
    parameter int IN_W      = OUTPUT_BUF_DATASIZE,
    parameter int INT_W     = FIXPOINT_INT,
    parameter int FRAC_W    = FIXPOINT_FRAC,
    parameter int LUT_DEPTH = SOFTMAX_LUT_DEPTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              softmax_en,
`ifdef SOFTMAX_TEMP_EN
    input  logic [1:0]                        temp_shift,
`endif
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [LANES*IN_W-1:0]             Xi,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [LANES*(INT_W+FRAC_W)-1:0]   out
);

    localparam int OUT_W     = INT_W + FRAC_W;
    localparam int LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int E_W       = FRAC_W + 1;
    localparam int SUM_W     = FRAC_W + $clog2(LANES) + 1;
    localparam int DIST_W    = IN_W + 1;
    localparam int Q_W       = FRAC_W + 1;
    localparam int DVD_W     = E_W + FRAC_W;
    localparam int SLOT_W    = $clog2(FRAC_W + 2);

    localparam logic [LANE_W-1:0] LANE_LAST   = LANE_W'(LANES - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST   = SLOT_W'(FRAC_W + 1);
    localparam logic [DIST_W-1:0] LUT_DEPTH_V = DIST_W'(LUT_DEPTH);

    logic [2:0]               state_r;
    logic signed [IN_W-1:0]   x_r [LANES];
    logic [1:0]               shift_r;
    logic [LANE_W-1:0]        lane_r;
    logic [LANE_W-1:0]        div_lane_r;
    logic [SLOT_W-1:0]        slot_r;
    logic signed [IN_W-1:0]   max_r;
    logic [E_W-1:0]           exp_r [LANES];
    logic [SUM_W-1:0]         sum_r;
    logic [OUT_W-1:0]         res_r [LANES];
    logic [LANES*OUT_W-1:0]   out_r;
    logic                     out_valid_r;
    logic                     in_ready_r;

    logic                     accept_s;
    logic [1:0]               shift_in_s;
    logic signed [IN_W-1:0]   cur_x_s;
    logic [DIST_W-1:0]        dist_s;
    logic [DIST_W-1:0]        idx_s;
    logic [E_W-1:0]           e_s;
    logic                     div_start_s;
    logic                     div_busy_s;
    logic                     div_done_s;
    logic [Q_W-1:0]           div_q_s;
    logic [OUT_W-1:0]         res_cur_s [LANES];
    logic [LANES*OUT_W-1:0]   out_next_s;

`ifdef SOFTMAX_TEMP_EN
    assign shift_in_s = temp_shift;
`else
    assign shift_in_s = 2'b00;
`endif

    // Integer to fixed point with saturation when the value leaves the INT_W signed range
    function automatic logic [OUT_W-1:0] to_fixed(input logic signed [IN_W-1:0] v);
        logic fits;
        fits = (v[IN_W-1:INT_W-1] == {(IN_W-INT_W+1){v[IN_W-1]}});
        if (fits) begin
            to_fixed = {v[INT_W-1:0], {FRAC_W{1'b0}}};
        end else if (v[IN_W-1]) begin
            to_fixed = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            to_fixed = {1'b0, {(OUT_W-1){1'b1}}};
        end
    endfunction

    assign accept_s = in_valid && in_ready_r && (state_r == ST_IDLE);
    assign cur_x_s  = x_r[lane_r];

    // Distance to the max is taken one bit wider so it can never wrap negative
    assign dist_s = {max_r[IN_W-1], max_r} - {cur_x_s[IN_W-1], cur_x_s};
    assign idx_s  = dist_s >> shift_r;

    // Exponent lookup; distances past the table end contribute nothing
    always_comb begin
        if (idx_s < LUT_DEPTH_V) begin
            e_s = E_W'(exp_lut(idx_s[3:0]));
        end else begin
            e_s = '0;
        end
    end

    // Each lane owns a FRAC_W+2 slot in DIV; the divider is started in slot 0
    assign div_start_s = (state_r == ST_DIV) && (slot_r == '0) && !div_busy_s;

    softmax_div_seq #(
        .DVD_W (DVD_W),
        .DVS_W (SUM_W),
        .Q_W   (Q_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start_s),
        .dividend ({exp_r[lane_r], {FRAC_W{1'b0}}}),
        .divisor  (sum_r),
        .busy     (div_busy_s),
        .done     (div_done_s),
        .quotient (div_q_s)
    );

    // Result view that already includes a quotient finishing this cycle (the last lane lands in DONE)
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            if (div_done_s && (div_lane_r == LANE_W'(i))) begin
                res_cur_s[i] = {{(OUT_W-Q_W){1'b0}}, div_q_s};
            end else begin
                res_cur_s[i] = res_r[i];
            end
        end
    end

    // Pack per-lane results, lane 0 in the LSBs
    always_comb begin
        out_next_s = '0;
        for (int i = 0; i < LANES; i++) begin
            out_next_s[i*OUT_W +: OUT_W] = res_cur_s[i];
        end
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            shift_r     <= 2'b00;
            lane_r      <= '0;
            div_lane_r  <= '0;
            slot_r      <= '0;
            max_r       <= '0;
            sum_r       <= '0;
            out_r       <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            for (int i = 0; i < LANES; i++) begin
                x_r[i]   <= '0;
                exp_r[i] <= '0;
                res_r[i] <= '0;
            end
        end else begin
            if (div_done_s) begin
                res_r[div_lane_r] <= {{(OUT_W-Q_W){1'b0}}, div_q_s};
            end
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        for (int i = 0; i < LANES; i++) begin
                            x_r[i] <= Xi[i*IN_W +: IN_W];
                        end
                        shift_r    <= shift_in_s;
                        lane_r     <= '0;
                        slot_r     <= '0;
                        in_ready_r <= 1'b0;
                        state_r    <= softmax_en ? ST_MAX : ST_BYP;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ST_BYP: begin
                    for (int i = 0; i < LANES; i++) begin
                        res_r[i] <= to_fixed(x_r[i]);
                    end
                    state_r <= ST_DONE;
                end
                ST_MAX: begin
                    if ((lane_r == '0) || (cur_x_s > max_r)) begin
                        max_r <= cur_x_s;
                    end else begin
                        max_r <= max_r;
                    end
                    if (lane_r == LANE_LAST) begin
                        lane_r  <= '0;
                        state_r <= ST_EXP;
                    end else begin
                        lane_r <= lane_r + LANE_W'(1);
                    end
                end
                ST_EXP: begin
                    exp_r[lane_r] <= e_s;
                    if (lane_r == '0) begin
                        sum_r <= SUM_W'(e_s);
                    end else begin
                        sum_r <= sum_r + SUM_W'(e_s);
                    end
                    if (lane_r == LANE_LAST) begin
                        lane_r  <= '0;
                        slot_r  <= '0;
                        state_r <= ST_DIV;
                    end else begin
                        lane_r <= lane_r + LANE_W'(1);
                    end
                end
                ST_DIV: begin
                    if (slot_r == '0) begin
                        div_lane_r <= lane_r;
                    end
                    if (slot_r == SLOT_LAST) begin
                        slot_r <= '0;
                        if (lane_r == LANE_LAST) begin
                            state_r <= ST_DONE;
                        end else begin
                            lane_r <= lane_r + LANE_W'(1);
                        end
                    end else begin
                        slot_r <= slot_r + SLOT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (!out_valid_r) begin
                        out_r       <= out_next_s;
                        out_valid_r <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out       = out_r;

endmodule

// File: tb/tb_softmax_seq.sv
// Directed, table-driven bench for softmax_seq at default parameters,
// plus hand-written backpressure, reset-abort and temperature sequences.
module tb_softmax_seq;

    localparam int LANES = 4;
    localparam int IN_W  = 32;
    localparam int OUT_W = 32;
    localparam int XW    = LANES * IN_W;
    localparam int OW    = LANES * OUT_W;
    localparam int TMO   = 200;

    logic          clk        = 1'b0;
    logic          rst        = 1'b0;
    logic          softmax_en = 1'b0;
    logic          in_valid   = 1'b0;
    logic          out_ready  = 1'b0;
    logic [XW-1:0] Xi         = '0;
    logic          in_ready;
    logic          out_valid;
    logic [OW-1:0] out;
`ifdef SOFTMAX_TEMP_EN
    logic [1:0]    temp_shift = 2'd0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string         name;
        logic          en;
        logic [XW-1:0] xi;
        logic [OW-1:0] expv;
        int            lat;
    } vec_t;

    vec_t vecs[6];

    localparam logic [XW-1:0] BASIC_X   = 128'h00000001_00000002_00000003_00000004;
    localparam logic [OW-1:0] BASIC_EXP = {32'd32, 32'd89, 32'd242, 32'd659};

    softmax_seq dut (
        .clk        (clk),
        .rst        (rst),
        .softmax_en (softmax_en),
`ifdef SOFTMAX_TEMP_EN
        .temp_shift (temp_shift),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Xi         (Xi),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, expv);
        end
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < TMO) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic launch(input logic en, input logic [XW-1:0] xi, input string name);
        @(negedge clk);
        check({name, "/in_ready_idle"}, OW'(in_ready), OW'(1'b1));
        softmax_en = en;
        Xi         = xi;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic handshake(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, "/valid_drop"}, OW'(out_valid), OW'(1'b0));
        check({name, "/in_ready_back"}, OW'(in_ready), OW'(1'b1));
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        launch(v.en, v.xi, v.name);
        wait_valid(cyc);
        check({v.name, "/latency"}, OW'(cyc), OW'(v.lat));
        check({v.name, "/out"}, out, v.expv);
        handshake(v.name);
    endtask

    initial begin
        int cyc;
        int seen;

        vecs[0] = '{"basic",    1'b1, BASIC_X, BASIC_EXP, 57};
        vecs[1] = '{"equal",    1'b1, {4{32'd7}}, {4{32'd256}}, 57};
        vecs[2] = '{"spread",   1'b1, {32'hFFFFFF9C, 32'd0, 32'd50, 32'd50},
                                      {32'd0, 32'd0, 32'd512, 32'd512}, 57};
        vecs[3] = '{"lut_edge", 1'b1, {32'd8, 32'd1, 32'd0, 32'd0},
                                      {32'd1023, 32'd0, 32'd0, 32'd0}, 57};
        vecs[4] = '{"bypass",   1'b0, {32'd3, 32'hFFFFFFFE, 32'h00400000, 32'd0},
                                      {32'd3072, 32'hFFFFF800, 32'h7FFFFFFF, 32'd0}, 2};
        vecs[5] = '{"byp_sat",  1'b0, {32'h001FFFFF, 32'hFFE00000, 32'h00200000, 32'hFFDFFFFF},
                                      {32'h7FFFFC00, 32'h80000000, 32'h7FFFFFFF, 32'h80000000}, 2};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst/out_valid", OW'(out_valid), OW'(1'b0));
        check("rst/out", out, '0);
        check("rst/in_ready", OW'(in_ready), OW'(1'b1));
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // backpressure: result held, new input ignored while DONE
        launch(1'b1, BASIC_X, "bp");
        wait_valid(cyc);
        check("bp/latency", OW'(cyc), OW'(57));
        @(negedge clk);
        in_valid   = 1'b1;
        softmax_en = 1'b0;
        Xi         = {4{32'h12345678}};
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("bp/out_hold", out, BASIC_EXP);
            check("bp/valid_hold", OW'(out_valid), OW'(1'b1));
            check("bp/in_ready_low", OW'(in_ready), OW'(1'b0));
        end
        @(negedge clk);
        in_valid = 1'b0;
        handshake("bp");
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        check("bp/no_extra_result", OW'(seen), OW'(0));

        // reset in the middle of a softmax operation
        launch(1'b1, BASIC_X, "abort");
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort/out_valid", OW'(out_valid), OW'(1'b0));
        check("abort/out", out, '0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort/in_ready", OW'(in_ready), OW'(1'b1));
        seen = 0;
        for (int k = 0; k < 70; k++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        check("abort/no_partial", OW'(seen), OW'(0));
        run_vec(vecs[0]);

`ifdef SOFTMAX_TEMP_EN
        temp_shift = 2'd1;
        launch(1'b1, BASIC_X, "temp");
        wait_valid(cyc);
        check("temp/latency", OW'(cyc), OW'(57));
        check("temp/out", out, {32'd137, 32'd137, 32'd374, 32'd374});
        handshake("temp");
        temp_shift = 2'd0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
